// File: rtl/score_disp_pkg.sv
// Shared types and glyph geometry for the score overlay digit path.
// Imported by the sequencer, its converter and its ROM interface.
package score_disp_pkg;

    localparam int GLYPH_W    = 14;
    localparam int GLYPH_H    = 25;
    localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        FETCH,
        WAIT,
        DONE
    } seq_state_t;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/score_digit_sequencer_if.sv
// Glyph ROM bus: one digit request out, one bitmap back.
// The sequencer is the master, the glyph ROM the slave.
interface score_digit_sequencer_if #(
    parameter int GLYPH_BITS = 350
);

    logic                  rom_req;
    logic [3:0]            rom_digit;
    logic [GLYPH_BITS-1:0] rom_bitmap;

    modport master (
        output rom_req,
        output rom_digit,
        input  rom_bitmap
    );

    modport slave (
        input  rom_req,
        input  rom_digit,
        output rom_bitmap
    );

endinterface

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: one binary bit per cycle, SCORE_W cycles.
// bcd is stable once done has pulsed, until the next start.
module bin2bcd_serial #(
    parameter int SCORE_W    = 8,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SCORE_W-1:0]      bin,
    output logic [NUM_DIGITS*4-1:0] bcd,
    output logic                    done
);

    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0]      sh;
    logic [CNT_W-1:0]        cnt;
    logic                    run;
    logic [NUM_DIGITS*4-1:0] adj;

    // add 3 to every nibble of 5 or more ahead of the shift
    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // load on start, then shift one binary bit into the BCD field per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            bcd <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            sh  <= bin;
            bcd <= '0;
            cnt <= CNT_W'(SCORE_W);
            run <= 1'b1;
        end else if (run) begin
            {bcd, sh} <= {adj, sh} << 1;
            cnt       <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                run <= 1'b0;
            end
        end
    end

    assign done = run && (cnt == CNT_W'(1));

endmodule

// File: rtl/score_digit_sequencer.sv
// Converts the score once per frame and fetches one glyph per digit
// through a shared ROM, publishing all bitmaps together.
module score_digit_sequencer
    import score_disp_pkg::*;
#(
    parameter int SCORE_W       = 8,
    parameter int NUM_DIGITS    = 3,
    parameter int GLYPH_BITS    = score_disp_pkg::GLYPH_BITS,
    parameter int ROM_LAT       = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             frame_clk,
    input  logic [SCORE_W-1:0]               total_Score,
    score_digit_sequencer_if.master          rom,
    output logic [NUM_DIGITS*GLYPH_BITS-1:0] digit_bitmap,
    output logic                             busy,
    output logic                             done
);

    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int LAT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [SLOT_W-1:0] TOP_SLOT = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [LAT_W-1:0]  LAST_LAT = LAT_W'(ROM_LAT - 1);

    seq_state_t state;
    seq_state_t state_n;

    logic sync1;
    logic sync2;
    logic prev;
    logic rise;
    logic pending;
    logic start;
    logic conv_done;
    logic capture;
    logic zero_run;

    logic [NUM_DIGITS*4-1:0] bcd;
    logic [SLOT_W-1:0]       slot;
    logic [LAT_W-1:0]        lat;
    logic [NUM_DIGITS-1:0]   blank;
    bcd_t                    nib;

    logic [NUM_DIGITS-1:0][GLYPH_BITS-1:0] shadow;
    logic [NUM_DIGITS-1:0][GLYPH_BITS-1:0] shadow_n;

    // bring the frame strobe into the Clk domain and keep its last value
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= frame_clk;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise  = sync2 & ~prev;
    assign start = (state == IDLE) && (rise || pending);

    bin2bcd_serial #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk   (Clk),
        .rst   (Reset),
        .start (start),
        .bin   (total_Score),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // a slot is blank while it and everything above it is zero
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int s = NUM_DIGITS - 1; s >= 0; s--) begin
            zero_run = zero_run & (bcd[s*4 +: 4] == 4'd0);
            blank[s] = (BLANK_LEADING != 0) && (s != 0) && zero_run;
        end
        nib = bcd[int'(slot)*4 +: 4];
    end

    // sequencer next state and ROM request
    always_comb begin
        state_n       = state;
        capture       = 1'b0;
        rom.rom_req   = 1'b0;
        rom.rom_digit = 4'd0;
        unique case (state)
            IDLE: begin
                if (start) state_n = CONVERT;
            end
            CONVERT: begin
                if (conv_done) state_n = FETCH;
            end
            FETCH: begin
                if (!blank[slot]) begin
                    rom.rom_req   = 1'b1;
                    rom.rom_digit = nib;
                end
                state_n = WAIT;
            end
            WAIT: begin
                if (lat == LAST_LAT) begin
                    capture = 1'b1;
                    state_n = (slot == '0) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = start || (state == CONVERT) ||
                  (state == FETCH) || (state == WAIT);
    assign done = (state == DONE);

    // shadow contents after this cycle's capture, if any
    always_comb begin
        shadow_n = shadow;
        if (capture) begin
            for (int s = 0; s < NUM_DIGITS; s++) begin
                if (SLOT_W'(s) == slot) begin
                    shadow_n[s] = blank[s] ? '0 : rom.rom_bitmap;
                end
            end
        end
    end

    // state, slot and latency counters, pending frame request
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            slot    <= '0;
            lat     <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                pending <= 1'b0;
            end else if (rise && (state != IDLE)) begin
                pending <= 1'b1;
            end
            if (state == CONVERT) begin
                slot <= TOP_SLOT;
            end else if (capture && (slot != '0)) begin
                slot <= slot - 1'b1;
            end
            if (state == FETCH) begin
                lat <= '0;
            end else if (state == WAIT) begin
                lat <= lat + 1'b1;
            end
        end
    end

    // shadow capture; publish all slots together with the last capture
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shadow       <= '0;
            digit_bitmap <= '0;
        end else begin
            shadow <= shadow_n;
            if (capture && (slot == '0)) begin
                digit_bitmap <= shadow_n;
            end
        end
    end

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Directed plus random frames against a digit-level score model.
// Two instances: default ROM latency and ROM_LAT=3.
module tb_score_digit_sequencer;

    localparam int GB = 350;
    localparam int ND = 3;
    localparam int SW = 8;
    localparam int LAT1 = 1 + SW + ND * (1 + 1);
    localparam int LAT3 = 1 + SW + ND * (1 + 3);

    typedef int intq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          fclk;
    logic          fclk3;
    logic [SW-1:0] score;
    logic [SW-1:0] score3;
    logic [ND*GB-1:0] bm;
    logic [ND*GB-1:0] bm3;
    logic busy, done, busy3, done3;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    score_digit_sequencer_if #(.GLYPH_BITS(GB)) rom1 ();
    score_digit_sequencer_if #(.GLYPH_BITS(GB)) rom3 ();

    score_digit_sequencer dut (
        .Clk          (clk),
        .Reset        (rst),
        .frame_clk    (fclk),
        .total_Score  (score),
        .rom          (rom1),
        .digit_bitmap (bm),
        .busy         (busy),
        .done         (done)
    );

    score_digit_sequencer #(.ROM_LAT(3)) dut3 (
        .Clk          (clk),
        .Reset        (rst),
        .frame_clk    (fclk3),
        .total_Score  (score3),
        .rom          (rom3),
        .digit_bitmap (bm3),
        .busy         (busy3),
        .done         (done3)
    );

    function automatic logic [GB-1:0] glyph(input logic [3:0] d);
        logic [31:0]  k;
        logic [351:0] w;
        k = 32'h9E3779B9 * (32'(d) + 32'd1);
        w = {11{k}};
        return w[GB-1:0];
    endfunction

    logic [351:0] junk_w = {11{32'hA5A55A5A}};
    logic [GB-1:0] junk;
    assign junk = junk_w[GB-1:0];

    logic [3:0]      v1 = '0;
    logic [3:0]      v3 = '0;
    logic [3:0][3:0] d1 = '0;
    logic [3:0][3:0] d3 = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        v1  <= {v1[2:0], rom1.rom_req};
        d1  <= {d1[2:0], rom1.rom_digit};
        v3  <= {v3[2:0], rom3.rom_req};
        d3  <= {d3[2:0], rom3.rom_digit};
    end

    assign rom1.rom_bitmap = v1[0] ? glyph(d1[0]) : junk;
    assign rom3.rom_bitmap = v3[2] ? glyph(d3[2]) : junk;

    int done_q[$];
    int done3_q[$];
    int req_q[$];
    int req3_dig[$];
    int req3_cyc[$];
    bit busy_h[int];

    always @(negedge clk) begin
        busy_h[cyc] = busy;
        if (done)  done_q.push_back(cyc);
        if (done3) done3_q.push_back(cyc);
        if (rom1.rom_req) req_q.push_back(int'(rom1.rom_digit));
        if (rom3.rom_req) begin
            req3_dig.push_back(int'(rom3.rom_digit));
            req3_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [GB-1:0] obs,
                       input logic [GB-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic intq_t exp_digits(input int s);
        intq_t q;
        if (s >= 100) q.push_back(s / 100);
        if (s >= 10)  q.push_back((s / 10) % 10);
        q.push_back(s % 10);
        return q;
    endfunction

    function automatic logic [GB-1:0] exp_slot(input int s, input int k);
        int d;
        d = (k == 0) ? s % 10 : (k == 1) ? (s / 10) % 10 : s / 100;
        if ((k == 2 && s < 100) || (k == 1 && s < 10)) return '0;
        return glyph(4'(d));
    endfunction

    function automatic int code_q(input intq_t q);
        int c;
        c = q.size();
        foreach (q[i]) c = c * 16 + q[i];
        return c;
    endfunction

    task automatic pulse(input bit which, output int t0);
        @(negedge clk);
        if (which) fclk3 = 1'b1;
        else       fclk  = 1'b1;
        t0 = cyc + 2;
        repeat (3) @(negedge clk);
        fclk  = 1'b0;
        fclk3 = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int target,
                             input int budget, input string tag);
        int k = 0;
        while (((which ? done3_q.size() : done_q.size()) < target)
               && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk({tag, " done_seen"},
            GB'((which ? done3_q.size() : done_q.size()) >= target), 1);
    endtask

    task automatic check_update(input int s, input int t0, input int idx,
                                input string tag);
        int bad = 0;
        chk({tag, " latency"}, GB'(done_q[idx] - t0), LAT1);
        for (int c = t0; c <= t0 + LAT1; c++) begin
            if (!busy_h.exists(c) || busy_h[c] != (c < t0 + LAT1)) bad++;
        end
        chk({tag, " busy_window"}, GB'(bad), 0);
        chk({tag, " rom_seq"}, GB'(code_q(req_q)), GB'(code_q(exp_digits(s))));
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("%s slot%0d", tag, k), bm[k*GB +: GB], exp_slot(s, k));
        end
    endtask

    task automatic run_update(input int s, input int chg_at, input int chg_val,
                              input string tag);
        int t0;
        int n;
        req_q.delete();
        score = SW'(s);
        n = done_q.size();
        pulse(1'b0, t0);
        if (chg_at >= 0) begin
            while (cyc < t0 + chg_at) @(negedge clk);
            score = SW'(chg_val);
        end
        wait_done(1'b0, n + 1, 40, tag);
        check_update(s, t0, n, tag);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int tx;
        int n;
        int s;

        rst = 1'b1;
        fclk = 1'b0;
        fclk3 = 1'b0;
        score = '0;
        score3 = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", GB'(busy), 0);
        chk("rst done", GB'(done), 0);
        chk("rst bitmap", GB'(bm == '0), 1);
        chk("rst rom_req", GB'(rom1.rom_req), 0);
        chk("rst rom_digit", GB'(rom1.rom_digit), 0);
        chk("rst busy3", GB'(busy3), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_update(0, -1, 0, "score0");
        run_update(205, -1, 0, "score205");
        run_update(255, 5, 17, "score255");
        run_update(17, -1, 0, "score17");
        run_update(9, -1, 0, "score9");
        run_update(100, -1, 0, "score100");
        for (int i = 0; i < 6; i++) begin
            s = int'($urandom_range(0, 255));
            run_update(s, -1, 0, $sformatf("rand%0d_%0d", i, s));
        end

        score = 8'd40;
        n = done_q.size();
        pulse(1'b0, t0);
        pulse(1'b0, tx);
        pulse(1'b0, tx);
        score = 8'd123;
        wait_done(1'b0, n + 2, 60, "pending");
        repeat (40) @(negedge clk);
        chk("pending count", GB'(done_q.size() - n), 2);
        chk("pending first", GB'(done_q[n] - t0), LAT1);
        chk("pending gap", GB'(done_q[n+1] - done_q[n]), 16);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("pending slot%0d", k), bm[k*GB +: GB], exp_slot(123, k));
        end

        score = 8'd99;
        pulse(1'b0, t0);
        pulse(1'b0, tx);
        while (cyc < t0 + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst busy", GB'(busy), 0);
        chk("midrst done", GB'(done), 0);
        chk("midrst bitmap", GB'(bm == '0), 1);
        chk("midrst rom_req", GB'(rom1.rom_req), 0);
        rst = 1'b0;
        n = done_q.size();
        repeat (40) @(negedge clk);
        chk("midrst no_done", GB'(done_q.size() - n), 0);
        chk("midrst hold", GB'(bm == '0), 1);

        score3 = 8'd7;
        pulse(1'b1, t0);
        wait_done(1'b1, 1, 60, "lat3");
        chk("lat3 latency", GB'(done3_q[0] - t0), LAT3);
        chk("lat3 req_count", GB'(req3_dig.size()), 1);
        chk("lat3 req_digit", GB'(req3_dig[0]), 7);
        chk("lat3 req_cycle", GB'(req3_cyc[0] - t0), 1 + SW + 2 * 4);
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("lat3 slot%0d", k), bm3[k*GB +: GB], exp_slot(7, k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
